bcd_to_bin: RTL and testbench
=============================

// Module: bcd_to_bin
// PURPOSE
//  Sequential packed-BCD to unsigned-binary converter; inverse of the BCD display path.
//  Converts DWIDTH/4 BCD digits (MSD in top nibble) to binary, one digit per clock:
//  acc = acc*10 + digit.
//  Sits between keypad/decimal entry logic and binary datapath; valid/ready both sides.
// PARAMETERS
//  DWIDTH  16  BCD input width; must be a multiple of 4; DIGITS = DWIDTH/4
//  BWIDTH  14  binary output width; 14 covers 9999 for 4 digits
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  bcd_in     in   DWIDTH  packed BCD operand, sampled on input handshake
//  in_valid   in   1       bcd_in valid
//  in_ready   out  1       converter idle, can accept an operand
//  bin_out    out  BWIDTH  binary result, held stable while out_valid=1
//  out_valid  out  1       bin_out, err_digit and err_ovf valid
//  out_ready  in   1       consumer accepts result
//  busy       out  1       conversion in progress (CONV state)
//  err_digit  out  1       some digit of the operand was > 9
//  err_ovf    out  1       result exceeded 2^BWIDTH-1, so bin_out is saturated
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; bin_out=0, out_valid=0, busy=0, err_digit=0,
//   err_ovf=0, in_ready=1, internal acc/shift/count cleared.
//  States: IDLE -> CONV -> DONE -> IDLE.
//   IDLE: in_ready=1. Edge with in_valid=1: load shift reg <= bcd_in; acc <= 0; cnt <= 0;
//    clear both error flags; go to CONV.
//   CONV: in_ready=0, busy=1. Each edge: d = shift[DWIDTH-1 -: 4];
//    acc <= acc*10 + d, computed at BWIDTH+4 bits;
//    shift <= shift<<4; cnt <= cnt+1.
//    - d>9: set err_digit (sticky); d is still used as-is (0..15), so the result stays deterministic.
//    - wide sum > 2^BWIDTH-1: set err_ovf (sticky) and set acc to all-ones; acc stays
//      all-ones for the remaining digits.
//    - On the edge where cnt = DIGITS-1: bin_out <= final acc, out_valid <= 1, go to DONE.
//   DONE: out_valid=1, busy=0, in_ready=0. bin_out and the error flags are held until
//    out_ready=1. The edge with out_ready=1 clears out_valid and returns to IDLE.
//    No new operand is accepted on that edge.
//  Latency: accept at edge N -> out_valid=1 after edge N+DIGITS (4 for default).
//   Minimum throughput: one operand per DIGITS+2 cycles.
//  in_valid during CONV/DONE: ignored (in_ready=0). bcd_in is don't-care outside the accept edge.
//  out_ready outside DONE: ignored.
//  Reset asserted mid-CONV or in DONE: conversion aborted, all outputs to reset values
//   immediately, with no partial result.
//  Error flags are meaningful only while out_valid=1; they are cleared on the next accept.
// TESTING
//  1 Reset: rst=0 then release -> in_ready=1, out_valid=0, busy=0, bin_out=0, errs=0.
//  2 bcd_in=16'h0243, in_valid pulse -> busy for 4 cycles, then out_valid=1,
//    bin_out=14'd243, errs=0.
//  3 bcd_in=16'h9999 -> bin_out=14'd9999; bcd_in=16'h0000 -> bin_out=0;
//    bcd_in=16'h0011 -> bin_out=11.
//  4 bcd_in=16'h00A1 -> err_digit=1, bin_out=101, err_ovf=0.
//  5 BWIDTH=12, bcd_in=16'h9999 -> err_ovf=1, bin_out=12'hFFF; bcd_in=16'h4095 -> 4095, err_ovf=0.
//  6 out_ready held low 5 cycles with in_valid=1 -> bin_out stable, in_ready=0, no second
//    accept. Separately, rst pulsed after 2 CONV cycles -> IDLE, out_valid never asserts.

Source files
------------

// File: rtl/bcd_to_bin.sv
// Sequential packed-BCD to binary converter: folds one BCD digit per clock,
// most significant first, into acc = acc*10 + digit, with valid/ready handshakes on both sides.
module bcd_to_bin #(
  parameter int DWIDTH = 16,
  parameter int BWIDTH = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] bcd_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [BWIDTH-1:0] bin_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              err_digit,
  output logic              err_ovf
);

  localparam int DIGITS = DWIDTH / 4;
  localparam int CW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int WW     = BWIDTH + 4;
  localparam logic [WW-1:0] MAX_WIDE = {4'b0000, {BWIDTH{1'b1}}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t              state_q, state_d;
  logic [DWIDTH-1:0]   shift_q, shift_d;
  logic [BWIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [BWIDTH-1:0]   bin_q, bin_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;
  logic                busy_q, busy_d;
  logic                err_digit_q, err_digit_d;
  logic                err_ovf_q, err_ovf_d;

  logic [3:0]          digit;
  logic [WW-1:0]       wide;
  logic                ovf;
  logic [BWIDTH-1:0]   acc_step;

  always_comb begin
    digit    = shift_q[DWIDTH-1 -: 4];
    wide     = WW'(acc_q) * WW'(10) + WW'(digit);
    ovf      = (wide > MAX_WIDE);
    // Once saturated, the accumulator is pinned at all-ones for the remaining digits.
    acc_step = (ovf || err_ovf_q) ? {BWIDTH{1'b1}} : wide[BWIDTH-1:0];

    state_d     = state_q;
    shift_d     = shift_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    bin_d       = bin_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    err_digit_d = err_digit_q;
    err_ovf_d   = err_ovf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shift_d     = bcd_in;
          acc_d       = '0;
          cnt_d       = '0;
          err_digit_d = 1'b0;
          err_ovf_d   = 1'b0;
          in_ready_d  = 1'b0;
          busy_d      = 1'b1;
          state_d     = CONV;
        end
      end
      CONV: begin
        acc_d   = acc_step;
        shift_d = shift_q << 4;
        cnt_d   = cnt_q + CW'(1);
        if (digit > 4'd9) err_digit_d = 1'b1;
        if (ovf)          err_ovf_d   = 1'b1;
        if (cnt_q == CW'(DIGITS - 1)) begin
          bin_d       = acc_step;
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = DONE;
        end
      end
      DONE: begin
        // The release edge does not accept a new operand; in_ready rises after it.
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      bin_q       <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      err_digit_q <= 1'b0;
      err_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      bin_q       <= bin_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
      err_digit_q <= err_digit_d;
      err_ovf_q   <= err_ovf_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign bin_out   = bin_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign err_digit = err_digit_q;
  assign err_ovf   = err_ovf_q;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Bench for bcd_to_bin: a 14-bit and a 12-bit instance share stimulus and are
// checked against a decimal-value reference model with saturation.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] bcd_in = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, busy, err_digit, err_ovf;
  logic [13:0] bin_out;
  logic        in_ready12, out_valid12, busy12, err_digit12, err_ovf12;
  logic [11:0] bin_out12;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bcd_to_bin #(.DWIDTH(16), .BWIDTH(14)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready),
    .bin_out(bin_out), .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .err_digit(err_digit), .err_ovf(err_ovf)
  );

  bcd_to_bin #(.DWIDTH(16), .BWIDTH(12)) dut12 (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .in_valid(in_valid), .in_ready(in_ready12),
    .bin_out(bin_out12), .out_valid(out_valid12), .out_ready(out_ready), .busy(busy12),
    .err_digit(err_digit12), .err_ovf(err_ovf12)
  );

  // Reference: decimal value of the digits (digits >9 taken at face value),
  // clamped to the output range; overflow flagged when clamping occurs.
  function automatic void model(input logic [15:0] bcd, input int bw,
                                output int res, output bit ed, output bit eo);
    int value;
    int maxv;
    value = 0;
    ed    = 1'b0;
    maxv  = (1 << bw) - 1;
    for (int i = 3; i >= 0; i--) begin
      int d;
      d = int'((bcd >> (4 * i)) & 16'hF);
      if (d > 9) ed = 1'b1;
      value = value * 10 + d;
    end
    eo  = (value > maxv);
    res = eo ? maxv : value;
  endfunction

  // Captured result of the last do_op.
  logic [13:0] cap_bin;
  logic        cap_ed, cap_eo, cap_v12;
  logic [11:0] cap_bin12;
  logic        cap_ed12, cap_eo12;

  // Called at a negedge; returns at the negedge following the release edge.
  task automatic do_op(input logic [15:0] bcd, output int lat, output int busy_cyc);
    bcd_in   = bcd;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    bcd_in   = 16'($urandom);
    lat      = 0;
    busy_cyc = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cyc++;
      @(negedge clk);
      lat++;
    end
    cap_bin   = bin_out;   cap_ed   = err_digit;   cap_eo   = err_ovf;
    cap_bin12 = bin_out12; cap_ed12 = err_digit12; cap_eo12 = err_ovf12;
    cap_v12   = out_valid12;
    $display("op bcd=%h lat=%0d bin14=%0d ed=%0b eo=%0b bin12=%0d ed12=%0b eo12=%0b",
             bcd, lat, cap_bin, cap_ed, cap_eo, cap_bin12, cap_ed12, cap_eo12);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b1 || in_ready12 !== 1'b1) $display("FAIL reset_in_ready got=%b/%b want=1", in_ready, in_ready12); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL reset_valid_busy got=%b/%b want=0/0", out_valid, busy); else n_pass++;
    n_checks++; if (bin_out !== 14'd0 || bin_out12 !== 12'd0) $display("FAIL reset_bin got=%0d/%0d want=0", bin_out, bin_out12); else n_pass++;
    n_checks++; if (err_digit !== 1'b0 || err_ovf !== 1'b0) $display("FAIL reset_errs got=%b/%b want=0/0", err_digit, err_ovf); else n_pass++;
  endtask

  task automatic check_op(input string name, input logic [15:0] bcd, input int lat, input int busy_cyc);
    int r14, r12;
    bit ed14, eo14, ed12, eo12;
    model(bcd, 14, r14, ed14, eo14);
    model(bcd, 12, r12, ed12, eo12);
    n_checks++; if (lat !== 4) $display("FAIL %s_latency bcd=%h got=%0d want=4", name, bcd, lat); else n_pass++;
    n_checks++; if (busy_cyc !== 4) $display("FAIL %s_busy bcd=%h got=%0d want=4", name, bcd, busy_cyc); else n_pass++;
    n_checks++; if (cap_bin !== 14'(r14)) $display("FAIL %s_bin14 bcd=%h got=%0d want=%0d", name, bcd, cap_bin, r14); else n_pass++;
    n_checks++; if (cap_ed !== ed14 || cap_eo !== eo14) $display("FAIL %s_err14 bcd=%h got=%b%b want=%b%b", name, bcd, cap_ed, cap_eo, ed14, eo14); else n_pass++;
    n_checks++; if (cap_v12 !== 1'b1 || cap_bin12 !== 12'(r12)) $display("FAIL %s_bin12 bcd=%h got=%0d v=%b want=%0d", name, bcd, cap_bin12, cap_v12, r12); else n_pass++;
    n_checks++; if (cap_ed12 !== ed12 || cap_eo12 !== eo12) $display("FAIL %s_err12 bcd=%h got=%b%b want=%b%b", name, bcd, cap_ed12, cap_eo12, ed12, eo12); else n_pass++;
  endtask

  task automatic test_directed();
    logic [15:0] vec [6] = '{16'h0243, 16'h9999, 16'h0000, 16'h0011, 16'h00A1, 16'h4095};
    int lat, bc;
    foreach (vec[i]) begin
      do_op(vec[i], lat, bc);
      check_op("directed", vec[i], lat, bc);
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [15:0] v;
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 7) == 0) v[4*k +: 4] = 4'($urandom_range(10, 15));
        else                           v[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      do_op(v, lat, bc);
      check_op("random", v, lat, bc);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [15:0] v;
    for (int n = 0; n < 3; n++) begin
      v = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      do_op(v, lat, bc);
      check_op("b2b", v, lat, bc);
      n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL b2b_idle got rdy=%b v=%b busy=%b want 1/0/0", in_ready, out_valid, busy); else n_pass++;
    end
  endtask

  task automatic test_hold();
    int lat;
    bcd_in   = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    n_checks++; if (out_valid !== 1'b1 || bin_out !== 14'd1234) $display("FAIL hold_first got v=%b bin=%0d want 1/1234", out_valid, bin_out); else n_pass++;
    in_valid = 1'b1;
    bcd_in   = 16'h0005;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_checks++; if (bin_out !== 14'd1234 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0)
        $display("FAIL hold_stable cyc=%0d got bin=%0d v=%b rdy=%b busy=%b want 1234/1/0/0", c, bin_out, out_valid, in_ready, busy);
      else n_pass++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) $display("FAIL hold_release got v=%b rdy=%b busy=%b want 0/1/0", out_valid, in_ready, busy); else n_pass++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) $display("FAIL hold_next_accept got busy=%b rdy=%b want 1/0", busy, in_ready); else n_pass++;
    lat = 0;
    while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
    n_checks++; if (out_valid !== 1'b1 || bin_out !== 14'd5) $display("FAIL hold_second got v=%b bin=%0d want 1/5", out_valid, bin_out); else n_pass++;
    $display("op bcd=0005 after hold bin14=%0d", bin_out);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int seen;
    bcd_in   = 16'h0777;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL abort_ctrl got v=%b busy=%b rdy=%b want 0/0/1", out_valid, busy, in_ready); else n_pass++;
    n_checks++; if (bin_out !== 14'd0 || err_digit !== 1'b0 || err_ovf !== 1'b0) $display("FAIL abort_data got bin=%0d ed=%b eo=%b want 0/0/0", bin_out, err_digit, err_ovf); else n_pass++;
    @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid || busy) seen++;
    end
    n_checks++; if (seen !== 0 || in_ready !== 1'b1) $display("FAIL abort_no_result got active=%0d rdy=%b want 0/1", seen, in_ready); else n_pass++;
    $display("op bcd=0777 aborted by reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_hold();
    test_reset_abort();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
